id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and operand-select stage between instruction decode and the execute-stage ALU. It latches decoded operands and control on each clock and decodes the ALU operation code. With forwarding compiled in, it resolves EX/MEM and MEM/WB bypasses and drives `alu_in1`, `alu_in2` and `alu_operation` straight into the ALU. It also flags load-use hazards to the decode stage.

## Interface
- `RESET_PC_NOP` (default 1): when 1, a reset or flush bubble drives `alu_operation` = 4'b0010 (ADD); when 0, it drives 4'b1111.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold all stage registers.
- `flush` in 1: load a bubble.
- `id_valid` in 1: the decode slot holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32: register file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in 5: register specifiers.
- `id_funct` in 6: R-type function field.
- `id_alu_op` in 2: main-control ALU class.
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: main-control bits.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM bypass source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB bypass source.
- `alu_in1`, `alu_in2` out 32: ALU operands.
- `alu_operation` out 4: ALU operation code.
- `ex_store_data` out 32: forwarded rt value for stores.
- `ex_write_reg` out 5: destination register.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: registered control.
- `hazard_stall` out 1: load-use hazard request to decode.

## Operation
- Register update on the rising edge of `clk`:
  - `flush` = 1: load a bubble.
  - else `stall` = 1: hold.
  - else: capture all `id_*` inputs.
  - `flush` has priority over `stall`.
- Bubble: `ex_valid` and all control bits = 0; data fields and register specifiers = 0.
- `ex_write_reg` = registered `reg_dst` ? `rd` : `rt`.
- Operation decode, combinational from registered fields:
  - `alu_op` 00 → 0010 (ADD).
  - `alu_op` 01 → 0110 (SUB).
  - `alu_op` 11 → 0001 (OR).
  - `alu_op` 10 → decode by funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 101010→0111; any other funct → 1111.
- A bubble overrides the decode with the `RESET_PC_NOP` value.
- Forwarding, applied separately to rs and rt:
  - If `exmem_reg_write` && `exmem_rd` != 0 && `exmem_rd` == reg, select `exmem_result`.
  - Else if the same condition holds for MEM/WB, select `memwb_result`.
  - Else select the registered file data.
  - EX/MEM beats MEM/WB; register 0 is never forwarded.
- Outputs:
  - `alu_in1` = forwarded rs.
  - `ex_store_data` = forwarded rt.
  - `alu_in2` = `alu_src` ? `imm` : forwarded rt.
- `hazard_stall` = `ex_valid` & `ex_mem_read` & (`ex_rt` != 0) & (`ex_rt` == `id_rs` | `ex_rt` == `id_rt`). Decode answers by asserting `stall` on IF/ID and `flush` on this block in the same cycle.

## Timing
- Latency: one cycle from `id_*` to registered state. Operand and operation outputs are combinational from that state and the current bypass inputs.
- Reset:
  - Asserting `rst_n` low immediately forces bubble state, regardless of clock, mid-operation included.
  - All outputs then read 0, except `alu_operation`, which takes the bubble value.
  - Release is synchronous to the next `clk` edge; the first capture occurs on that edge.
- `hazard_stall` is combinational: valid in the same cycle as the `id_*` inputs it compares.
- The stall may hold any number of cycles. Bypass inputs are re-sampled every cycle while holding, so a held instruction picks up newly forwardable values.

## Configuration
- `ID_EX_FORWARDING_EN` defined:
  - Bypass muxes and `hazard_stall` logic are present as described.
- `ID_EX_FORWARDING_EN` undefined:
  - Operands come only from registered file data.
  - `exmem_*` and `memwb_*` are ignored.
  - `hazard_stall` is tied to 0.
  - Software scheduling guarantees no RAW dependency within three instructions.

## Structure
- A shared package `cpu_pkg` holds:
  - ALU operation codes: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`, `ALU_INV`.
  - `alu_op` class constants.
  - Funct constants.
- One sub-module, `alu_control`: combinational map from (`alu_op`, `funct`) to the 4-bit operation.
- Forwarding muxes and the hazard comparator stay inline.

## Test plan
- Reset with `rst_n` low mid-cycle → `ex_valid`=0, `alu_in1`=0, `alu_in2`=0, `alu_operation`=0010, `hazard_stall`=0.
- R-type `sub`: rs_data=10, rt_data=3, funct 100010, `alu_op`=10 → next cycle `alu_in1`=10, `alu_in2`=3, `alu_operation`=0110, `ex_write_reg`=rd.
- `lw` (`alu_op` 00, `alu_src`=1, imm=0xFFFFFFFC) → `alu_in2`=0xFFFFFFFC, operation 0010.
- Double bypass: `exmem_rd`=`memwb_rd`=5, results 0xAA and 0xBB, rs=5 → `alu_in1`=0xAA. The same case with rs=0 → registered data.
- Load-use: EX holds `lw` to r7 and `id_rs`=7 → `hazard_stall`=1. `stall`=1 with `flush`=1 → bubble loaded.
- `stall` held 3 cycles → outputs unchanged. Changing `exmem_result` during the hold updates `alu_in1` the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, main-control ALU classes,
// R-type funct values and the ID/EX pipeline register layout.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_INV = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // An all-zero value of this struct is the pipeline bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX stage, the bypass sources and the ALU.
// The master side drives decode and bypass inputs; the stage is the slave.
interface id_ex_stage_if;

  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;

  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_operation;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        hazard_stall;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_funct, id_alu_op, id_alu_src, id_reg_dst,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_in1, alu_in2, alu_operation, ex_store_data, ex_write_reg,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           hazard_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_funct, id_alu_op, id_alu_src, id_reg_dst,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_in1, alu_in2, alu_operation, ex_store_data, ex_write_reg,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           hazard_stall
  );

endinterface

// File: rtl/id_ex_stage_alu_control.sv
// ALU control: maps the main-control ALU class and R-type funct field
// to the 4-bit ALU operation code.
module alu_control
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_operation_o
);

  always_comb begin
    alu_operation_o = ALU_INV;
    case (alu_op_i)
      ALUOP_ADD: alu_operation_o = ALU_ADD;
      ALUOP_SUB: alu_operation_o = ALU_SUB;
      ALUOP_OR:  alu_operation_o = ALU_OR;
      default: begin
        case (funct_i)
          FUNCT_ADD: alu_operation_o = ALU_ADD;
          FUNCT_SUB: alu_operation_o = ALU_SUB;
          FUNCT_AND: alu_operation_o = ALU_AND;
          FUNCT_OR:  alu_operation_o = ALU_OR;
          FUNCT_NOR: alu_operation_o = ALU_NOR;
          FUNCT_SLT: alu_operation_o = ALU_SLT;
          default:   alu_operation_o = ALU_INV;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand select and operation decode.
// Define ID_EX_FORWARDING_EN to build in EX/MEM, MEM/WB bypass and load-use detection.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter bit RESET_PC_NOP = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [3:0] BUBBLE_OP = RESET_PC_NOP ? ALU_ADD : ALU_INV;

  id_ex_t      state_d, state_q;
  logic [3:0]  decoded_op;
  logic [31:0] rs_fwd, rt_fwd;

  // Flush wins over stall so decode can hold IF/ID and insert a bubble here together.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = '0;
    end else if (!bus.stall) begin
      state_d.valid      = bus.id_valid;
      state_d.rs_data    = bus.id_rs_data;
      state_d.rt_data    = bus.id_rt_data;
      state_d.imm        = bus.id_imm;
      state_d.rs         = bus.id_rs;
      state_d.rt         = bus.id_rt;
      state_d.rd         = bus.id_rd;
      state_d.funct      = bus.id_funct;
      state_d.alu_op     = bus.id_alu_op;
      state_d.alu_src    = bus.id_alu_src;
      state_d.reg_dst    = bus.id_reg_dst;
      state_d.reg_write  = bus.id_reg_write;
      state_d.mem_read   = bus.id_mem_read;
      state_d.mem_write  = bus.id_mem_write;
      state_d.mem_to_reg = bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  alu_control u_alu_control (
    .alu_op_i        (state_q.alu_op),
    .funct_i         (state_q.funct),
    .alu_operation_o (decoded_op)
  );

  // Bypass sources are live inputs, so a held instruction keeps picking up fresh results.
  always_comb begin
    rs_fwd = state_q.rs_data;
    rt_fwd = state_q.rt_data;
`ifdef ID_EX_FORWARDING_EN
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == state_q.rs)) begin
      rs_fwd = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == state_q.rs)) begin
      rs_fwd = bus.memwb_result;
    end
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == state_q.rt)) begin
      rt_fwd = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == state_q.rt)) begin
      rt_fwd = bus.memwb_result;
    end
`endif
  end

`ifdef ID_EX_FORWARDING_EN
  assign bus.hazard_stall = state_q.valid && state_q.mem_read && (state_q.rt != 5'd0) &&
                            ((state_q.rt == bus.id_rs) || (state_q.rt == bus.id_rt));
`else
  logic fwd_unused;
  assign fwd_unused = ^{state_q.rs, bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                        bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result};
  assign bus.hazard_stall = 1'b0;
`endif

  assign bus.alu_in1       = rs_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.alu_in2       = state_q.alu_src ? state_q.imm : rt_fwd;
  assign bus.alu_operation = state_q.valid ? decoded_op : BUBBLE_OP;
  assign bus.ex_write_reg  = state_q.reg_dst ? state_q.rd : state_q.rt;
  assign bus.ex_valid      = state_q.valid;
  assign bus.ex_reg_write  = state_q.reg_write;
  assign bus.ex_mem_read   = state_q.mem_read;
  assign bus.ex_mem_write  = state_q.mem_write;
  assign bus.ex_mem_to_reg = state_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX slot held in the bench.
module tb_id_ex_stage;

  localparam bit NOP_P = 1'b1;
`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  id_ex_stage_if bus ();

  id_ex_stage #(.RESET_PC_NOP(NOP_P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model of what instruction currently sits in EX.
  typedef struct {
    bit          valid;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    bit          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
  } slot_t;

  slot_t       m;
  logic [3:0]  functTab [int];
  logic [31:0] e_in1, e_in2, e_store;
  logic [3:0]  e_op;
  logic [4:0]  e_wreg;
  logic        e_haz;

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.rsd = 0; s.rtd = 0; s.imm = 0; s.rs = 0; s.rt = 0; s.rd = 0;
    s.funct = 0; s.aluop = 0; s.alu_src = 0; s.reg_dst = 0; s.reg_write = 0;
    s.mem_read = 0; s.mem_write = 0; s.mem_to_reg = 0;
    return s;
  endfunction

  function automatic logic [31:0] fwd_val(logic [4:0] r, logic [31:0] regval);
    if (FWD_EN && bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == r) return bus.exmem_result;
    if (FWD_EN && bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == r) return bus.memwb_result;
    return regval;
  endfunction

  function automatic logic [3:0] exp_op();
    if (!m.valid) return NOP_P ? 4'b0010 : 4'b1111;
    if (m.aluop == 2'b00) return 4'b0010;
    if (m.aluop == 2'b01) return 4'b0110;
    if (m.aluop == 2'b11) return 4'b0001;
    if (functTab.exists(int'(m.funct))) return functTab[int'(m.funct)];
    return 4'b1111;
  endfunction

  task automatic predict();
    e_in1   = fwd_val(m.rs, m.rsd);
    e_store = fwd_val(m.rt, m.rtd);
    e_in2   = m.alu_src ? m.imm : e_store;
    e_op    = exp_op();
    e_wreg  = m.reg_dst ? m.rd : m.rt;
    e_haz   = FWD_EN && m.valid && m.mem_read && m.rt != 0 && (m.rt == bus.id_rs || m.rt == bus.id_rt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || bus.flush) m = empty_slot();
    else if (!bus.stall) begin
      m.valid = bus.id_valid; m.rsd = bus.id_rs_data; m.rtd = bus.id_rt_data; m.imm = bus.id_imm;
      m.rs = bus.id_rs; m.rt = bus.id_rt; m.rd = bus.id_rd; m.funct = bus.id_funct;
      m.aluop = bus.id_alu_op; m.alu_src = bus.id_alu_src; m.reg_dst = bus.id_reg_dst;
      m.reg_write = bus.id_reg_write; m.mem_read = bus.id_mem_read;
      m.mem_write = bus.id_mem_write; m.mem_to_reg = bus.id_mem_to_reg;
    end
    #1;
  endtask

  task automatic drive_instr(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                             logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                             logic [5:0] funct, logic [1:0] aluop, logic [5:0] ctl);
    bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_funct = funct; bus.id_alu_op = aluop;
    {bus.id_alu_src, bus.id_reg_dst, bus.id_reg_write,
     bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg} = ctl;
  endtask

  task automatic no_bypass();
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic test_reset();
    bus.stall = 0; bus.flush = 0; no_bypass();
    drive_instr(5'd3, 5'd4, 5'd5, 32'h1234, 32'h5678, 32'h9, 6'b100100, 2'b10, 6'b011100);
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_valid: got %b want 0", bus.ex_valid); end
    rst_n = 1'b1;
    tick();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_first_capture: got %b want 1", bus.ex_valid); end
    #3 rst_n = 1'b0; m = empty_slot();
    #1;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", bus.ex_valid); end
    total++; if (bus.alu_in1 !== 32'h0) begin bad++; $display("[TB] FAIL rst_in1: got %h want 0", bus.alu_in1); end
    total++; if (bus.alu_in2 !== 32'h0) begin bad++; $display("[TB] FAIL rst_in2: got %h want 0", bus.alu_in2); end
    total++; if (bus.alu_operation !== 4'b0010) begin bad++; $display("[TB] FAIL rst_op: got %b want 0010", bus.alu_operation); end
    total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_hazard: got %b want 0", bus.hazard_stall); end
    total++; if ({bus.ex_write_reg, bus.ex_store_data, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg} !== '0) begin
      bad++; $display("[TB] FAIL rst_others: wreg=%h store=%h ctl=%b%b%b%b want all 0", bus.ex_write_reg,
                      bus.ex_store_data, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype_sub();
    no_bypass();
    drive_instr(5'd1, 5'd2, 5'd9, 32'd10, 32'd3, 32'h0, 6'b100010, 2'b10, 6'b011000);
    tick();
    total++; if (bus.alu_in1 !== 32'd10) begin bad++; $display("[TB] FAIL sub_in1: got %0d want 10", bus.alu_in1); end
    total++; if (bus.alu_in2 !== 32'd3) begin bad++; $display("[TB] FAIL sub_in2: got %0d want 3", bus.alu_in2); end
    total++; if (bus.alu_operation !== 4'b0110) begin bad++; $display("[TB] FAIL sub_op: got %b want 0110", bus.alu_operation); end
    total++; if (bus.ex_write_reg !== 5'd9) begin bad++; $display("[TB] FAIL sub_wreg: got %0d want 9", bus.ex_write_reg); end
    total++; if (bus.ex_reg_write !== 1'b1) begin bad++; $display("[TB] FAIL sub_regwrite: got %b want 1", bus.ex_reg_write); end
  endtask

  task automatic test_lw();
    no_bypass();
    drive_instr(5'd2, 5'd4, 5'd0, 32'h1000, 32'h77, 32'hFFFF_FFFC, 6'b000000, 2'b00, 6'b101101);
    tick();
    total++; if (bus.alu_in2 !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL lw_in2: got %h want fffffffc", bus.alu_in2); end
    total++; if (bus.alu_operation !== 4'b0010) begin bad++; $display("[TB] FAIL lw_op: got %b want 0010", bus.alu_operation); end
    total++; if (bus.ex_write_reg !== 5'd4) begin bad++; $display("[TB] FAIL lw_wreg: got %0d want 4", bus.ex_write_reg); end
    total++; if (bus.ex_store_data !== 32'h77) begin bad++; $display("[TB] FAIL lw_store: got %h want 77", bus.ex_store_data); end
    total++; if ({bus.ex_mem_read, bus.ex_mem_to_reg} !== 2'b11) begin bad++; $display("[TB] FAIL lw_ctl: got %b want 11", {bus.ex_mem_read, bus.ex_mem_to_reg}); end
  endtask

  task automatic test_double_bypass();
    logic [31:0] want;
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'hBB;
    drive_instr(5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 32'h0, 6'b100000, 2'b10, 6'b011000);
    tick();
    want = FWD_EN ? 32'hAA : 32'h11;
    total++; if (bus.alu_in1 !== want) begin bad++; $display("[TB] FAIL dbl_in1: got %h want %h", bus.alu_in1, want); end
    bus.exmem_reg_write = 0;
    #1;
    want = FWD_EN ? 32'hBB : 32'h11;
    total++; if (bus.alu_in1 !== want) begin bad++; $display("[TB] FAIL memwb_in1: got %h want %h", bus.alu_in1, want); end
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd6; bus.memwb_rd = 5'd6;
    #1;
    want = FWD_EN ? 32'hAA : 32'h22;
    total++; if (bus.alu_in2 !== want) begin bad++; $display("[TB] FAIL dbl_in2: got %h want %h", bus.alu_in2, want); end
    bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
    drive_instr(5'd0, 5'd0, 5'd8, 32'h33, 32'h44, 32'h0, 6'b100000, 2'b10, 6'b011000);
    tick();
    total++; if (bus.alu_in1 !== 32'h33) begin bad++; $display("[TB] FAIL r0_in1: got %h want 33", bus.alu_in1); end
    total++; if (bus.alu_in2 !== 32'h44) begin bad++; $display("[TB] FAIL r0_in2: got %h want 44", bus.alu_in2); end
    no_bypass();
  endtask

  task automatic test_load_use();
    no_bypass();
    drive_instr(5'd1, 5'd7, 5'd0, 32'h100, 32'h0, 32'h4, 6'b000000, 2'b00, 6'b101101);
    tick();
    bus.id_rs = 5'd7; bus.id_rt = 5'd3;
    #1;
    total++; if (bus.hazard_stall !== FWD_EN) begin bad++; $display("[TB] FAIL lu_rs: got %b want %b", bus.hazard_stall, FWD_EN); end
    bus.id_rs = 5'd2; bus.id_rt = 5'd7;
    #1;
    total++; if (bus.hazard_stall !== FWD_EN) begin bad++; $display("[TB] FAIL lu_rt: got %b want %b", bus.hazard_stall, FWD_EN); end
    bus.id_rs = 5'd1; bus.id_rt = 5'd1;
    #1;
    total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_none: got %b want 0", bus.hazard_stall); end
    bus.id_rs = 5'd7; bus.stall = 1; bus.flush = 1;
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      bad++; $display("[TB] FAIL lu_bubble: got valid=%b memrd=%b want 0 0", bus.ex_valid, bus.ex_mem_read);
    end
    total++; if (bus.alu_operation !== 4'b0010) begin bad++; $display("[TB] FAIL lu_bubble_op: got %b want 0010", bus.alu_operation); end
    total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble_haz: got %b want 0", bus.hazard_stall); end
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic test_stall_hold();
    logic [31:0] want;
    no_bypass();
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h300;
    drive_instr(5'd3, 5'd4, 5'd10, 32'h100, 32'h200, 32'h0, 6'b100101, 2'b10, 6'b011000);
    tick();
    drive_instr(5'd9, 5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 32'h5, 6'b101010, 2'b01, 6'b100010);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = FWD_EN ? 32'h300 : 32'h100;
      total++; if (bus.alu_in1 !== want) begin bad++; $display("[TB] FAIL hold_in1[%0d]: got %h want %h", i, bus.alu_in1, want); end
      total++; if (bus.alu_in2 !== 32'h200) begin bad++; $display("[TB] FAIL hold_in2[%0d]: got %h want 200", i, bus.alu_in2); end
      total++; if (bus.alu_operation !== 4'b0001 || bus.ex_write_reg !== 5'd10) begin
        bad++; $display("[TB] FAIL hold_op[%0d]: got op=%b wreg=%0d want 0001 10", i, bus.alu_operation, bus.ex_write_reg);
      end
    end
    bus.exmem_result = 32'h400;
    #1;
    want = FWD_EN ? 32'h400 : 32'h100;
    total++; if (bus.alu_in1 !== want) begin bad++; $display("[TB] FAIL hold_refwd: got %h want %h", bus.alu_in1, want); end
    bus.stall = 0;
    no_bypass();
  endtask

  task automatic test_random();
    logic [5:0] functs [7];
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000};
    for (int i = 0; i < 80; i++) begin
      drive_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 6)],
                  2'($urandom), 6'($urandom));
      bus.id_valid = ($urandom_range(0, 7) != 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_result = $urandom;
      tick();
      predict();
      total++; if (bus.alu_in1 !== e_in1) begin bad++; $display("[TB] FAIL rnd_in1[%0d]: got %h want %h", i, bus.alu_in1, e_in1); end
      total++; if (bus.alu_in2 !== e_in2) begin bad++; $display("[TB] FAIL rnd_in2[%0d]: got %h want %h", i, bus.alu_in2, e_in2); end
      total++; if (bus.ex_store_data !== e_store) begin bad++; $display("[TB] FAIL rnd_store[%0d]: got %h want %h", i, bus.ex_store_data, e_store); end
      total++; if (bus.alu_operation !== e_op) begin bad++; $display("[TB] FAIL rnd_op[%0d]: got %b want %b", i, bus.alu_operation, e_op); end
      total++; if (bus.ex_write_reg !== e_wreg) begin bad++; $display("[TB] FAIL rnd_wreg[%0d]: got %0d want %0d", i, bus.ex_write_reg, e_wreg); end
      total++; if (bus.hazard_stall !== e_haz) begin bad++; $display("[TB] FAIL rnd_haz[%0d]: got %b want %b", i, bus.hazard_stall, e_haz); end
      total++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg} !==
                   {m.valid, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg}) begin
        bad++; $display("[TB] FAIL rnd_ctl[%0d]: got %b want %b", i,
                        {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg},
                        {m.valid, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg});
      end
    end
    bus.stall = 0; bus.flush = 0;
  endtask

  initial begin
    functTab[32] = 4'b0010; functTab[34] = 4'b0110; functTab[36] = 4'b0000;
    functTab[37] = 4'b0001; functTab[39] = 4'b1100; functTab[42] = 4'b0111;
    m = empty_slot();
    test_reset();
    test_rtype_sub();
    test_lw();
    test_double_bypass();
    test_load_use();
    test_stall_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
